// File: rtl/cmd_pro_gen.sv
// cmd_pro_gen: three-word command processor (opcode, A, B) feeding a WIDTH-bit ALU,
// with inter-word timeout and error pulse. Define CMD_PRO_STATUS_EN for a trailing {carry, zero} word.
module cmd_pro_gen #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] din_pro,
  input  logic             en_din_pro,
  input  logic             tx_busy,
  output logic [WIDTH-1:0] dout_pro,
  output logic             en_dout_pro,
  output logic             err,
  output logic             idle
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    GET_A,
    GET_B,
    CALC,
    SEND
`ifdef CMD_PRO_STATUS_EN
    , SEND_ST
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] alu_res;
  logic             op_legal;
`ifdef CMD_PRO_STATUS_EN
  logic             alu_carry;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
`endif

  assign dout_pro    = dout_q;
  assign en_dout_pro = en_q;
  assign err         = err_q;
  assign idle        = (state_q == IDLE);
  assign op_legal    = (din_pro[7:0] >= 8'h0A) && (din_pro[7:0] <= 8'h0F);

  always_comb begin
    alu_res = '0;
`ifdef CMD_PRO_STATUS_EN
    alu_carry = 1'b0;
`endif
    case (op_q)
      8'h0A: begin
`ifdef CMD_PRO_STATUS_EN
        {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
`else
        alu_res = a_q + b_q;
`endif
      end
      8'h0B: begin
        alu_res = a_q - b_q;
`ifdef CMD_PRO_STATUS_EN
        alu_carry = (a_q < b_q);
`endif
      end
      8'h0C:   alu_res = a_q & b_q;
      8'h0D:   alu_res = a_q | b_q;
      8'h0E:   alu_res = a_q ^ b_q;
      8'h0F:   alu_res = a_q << b_q[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
`ifdef CMD_PRO_STATUS_EN
    carry_d = carry_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_din_pro) begin
          if (op_legal) begin
            op_d    = din_pro[7:0];
            state_d = GET_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_A, GET_B: begin
        if (en_din_pro) begin
          cnt_d = '0;
          if (state_q == GET_A) begin
            a_d     = din_pro;
            state_d = GET_B;
          end else begin
            b_d     = din_pro;
            state_d = CALC;
          end
        end else if (TIMEOUT != 0) begin
          // A word on the edge the counter would reach TIMEOUT wins over the timeout.
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CALC: begin
        dout_d  = alu_res;
`ifdef CMD_PRO_STATUS_EN
        carry_d = alu_carry;
        zero_d  = (alu_res == '0);
`endif
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          en_d = 1'b1;
`ifdef CMD_PRO_STATUS_EN
          state_d = SEND_ST;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef CMD_PRO_STATUS_EN
      SEND_ST: begin
        if (!tx_busy) begin
          dout_d      = '0;
          dout_d[1:0] = {carry_q, zero_q};
          en_d        = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef CMD_PRO_STATUS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      err_q   <= err_d;
`ifdef CMD_PRO_STATUS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_cmd_pro_gen.sv
// Directed self-checking bench for cmd_pro_gen: an 8-bit instance with TIMEOUT=4 and a 32-bit instance.
// Status-word expectations follow CMD_PRO_STATUS_EN when it is defined for the build.
module tb_cmd_pro_gen;

  logic        clk = 1'b0;
  logic        res8, res32;
  logic [7:0]  din8;
  logic        en8, busy8, endo8, err8, idle8;
  logic [7:0]  dout8;
  logic [31:0] din32, dout32;
  logic        en32, busy32, endo32, err32, idle32;
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  cmd_pro_gen #(.WIDTH(8), .TIMEOUT(4)) dut8 (
    .clk(clk), .res(res8), .din_pro(din8), .en_din_pro(en8), .tx_busy(busy8),
    .dout_pro(dout8), .en_dout_pro(endo8), .err(err8), .idle(idle8)
  );

  cmd_pro_gen #(.WIDTH(32)) dut32 (
    .clk(clk), .res(res32), .din_pro(din32), .en_din_pro(en32), .tx_busy(busy32),
    .dout_pro(dout32), .en_dout_pro(endo32), .err(err32), .idle(idle32)
  );

  // Words are driven on the falling edge and sampled by the next rising edge;
  // returns on the falling edge just after B was taken, with the strobe lowered.
  task automatic send8(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    din8 = op; en8 = 1'b1; @(negedge clk);
    din8 = a;  @(negedge clk);
    din8 = b;  @(negedge clk);
    en8 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
    din32 = op; en32 = 1'b1; @(negedge clk);
    din32 = a;  @(negedge clk);
    din32 = b;  @(negedge clk);
    en32 = 1'b0;
  endtask

  // Falling edges until the output strobe is seen, bounded at 40.
  task automatic wait8(output int cyc, output logic [7:0] v);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (endo8 !== 1'b1 && cyc < 40);
    v = dout8;
  endtask

  task automatic wait32(output int cyc, output logic [31:0] v);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (endo32 !== 1'b1 && cyc < 40);
    v = dout32;
  endtask

  task automatic test_reset;
    @(negedge clk);
    nchk++; if ({dout8, endo8, err8, idle8} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      nerr++; $display("[TB] FAIL reset8 got dout=%h en=%b err=%b idle=%b", dout8, endo8, err8, idle8);
    end
    nchk++; if ({dout32, endo32, err32, idle32} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      nerr++; $display("[TB] FAIL reset32 got dout=%h en=%b err=%b idle=%b", dout32, endo32, err32, idle32);
    end
    res8 = 1'b1; res32 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    int cyc;
    logic [7:0] v;
    send8(8'h0A, 8'hF0, 8'h20);
    wait8(cyc, v);
    nchk++; if (cyc !== 2) begin nerr++; $display("[TB] FAIL add_latency got %0d exp 2", cyc); end
    nchk++; if (v !== 8'h10) begin nerr++; $display("[TB] FAIL add_result got %h exp 10", v); end
    @(negedge clk);
`ifdef CMD_PRO_STATUS_EN
    nchk++; if ({endo8, dout8} !== {1'b1, 8'h02}) begin
      nerr++; $display("[TB] FAIL add_status got en=%b dout=%h exp 1/02", endo8, dout8);
    end
    @(negedge clk);
`endif
    nchk++; if ({endo8, idle8} !== 2'b01) begin
      nerr++; $display("[TB] FAIL add_single_strobe got en=%b idle=%b exp 0/1", endo8, idle8);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [7:0] v;
    send8(8'h0B, 8'h05, 8'h05);
    wait8(cyc, v);
    nchk++; if (v !== 8'h00) begin nerr++; $display("[TB] FAIL sub_result got %h exp 00", v); end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
    nchk++; if ({endo8, dout8} !== {1'b1, 8'h01}) begin
      nerr++; $display("[TB] FAIL sub_status got en=%b dout=%h exp 1/01", endo8, dout8);
    end
`endif
    send8(8'h0F, 8'h81, 8'h09);
    wait8(cyc, v);
    nchk++; if (cyc !== 2) begin nerr++; $display("[TB] FAIL shl_latency got %0d exp 2", cyc); end
    nchk++; if (v !== 8'h02) begin nerr++; $display("[TB] FAIL shl_result got %h exp 02", v); end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
    nchk++; if ({endo8, dout8} !== {1'b1, 8'h00}) begin
      nerr++; $display("[TB] FAIL shl_status got en=%b dout=%h exp 1/00", endo8, dout8);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_bad_opcode;
    int cyc, pulses, errs;
    logic [7:0] v;
    pulses = 0; errs = 0;
    din8 = 8'h33; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    nchk++; if ({err8, idle8} !== 2'b11) begin
      nerr++; $display("[TB] FAIL badop_err got err=%b idle=%b exp 1/1", err8, idle8);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (endo8) pulses++;
      if (err8) errs++;
    end
    nchk++; if ({pulses, errs} !== {32'd0, 32'd0}) begin
      nerr++; $display("[TB] FAIL badop_quiet got strobes=%0d errs=%0d exp 0/0", pulses, errs);
    end
    nchk++; if (idle8 !== 1'b1) begin nerr++; $display("[TB] FAIL badop_idle got %b exp 1", idle8); end
    send8(8'h0E, 8'hAA, 8'hFF);
    wait8(cyc, v);
    nchk++; if (v !== 8'h55) begin nerr++; $display("[TB] FAIL xor_result got %h exp 55", v); end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
`endif
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int cyc;
    logic [7:0] v;
    din8 = 8'h0C; en8 = 1'b1; @(negedge clk);
    din8 = 8'h3C; @(negedge clk);
    en8 = 1'b0;
    repeat (3) @(negedge clk);
    nchk++; if ({err8, idle8} !== 2'b00) begin
      nerr++; $display("[TB] FAIL tmo_before got err=%b idle=%b exp 0/0", err8, idle8);
    end
    @(negedge clk);
    nchk++; if ({err8, idle8} !== 2'b11) begin
      nerr++; $display("[TB] FAIL tmo_fire got err=%b idle=%b exp 1/1", err8, idle8);
    end
    @(negedge clk);
    nchk++; if (err8 !== 1'b0) begin nerr++; $display("[TB] FAIL tmo_pulse_width got %b exp 0", err8); end
    din8 = 8'h0C; en8 = 1'b1; @(negedge clk);
    din8 = 8'h3C; @(negedge clk);
    en8 = 1'b0;
    repeat (3) @(negedge clk);
    din8 = 8'h0F; en8 = 1'b1; @(negedge clk);
    en8 = 1'b0;
    nchk++; if ({err8, idle8} !== 2'b00) begin
      nerr++; $display("[TB] FAIL tmo_boundary got err=%b idle=%b exp 0/0", err8, idle8);
    end
    wait8(cyc, v);
    nchk++; if ({cyc, v} !== {32'd2, 8'h0C}) begin
      nerr++; $display("[TB] FAIL tmo_late_frame got cyc=%0d dout=%h exp 2/0c", cyc, v);
    end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
`endif
    @(negedge clk);
  endtask

  task automatic test_busy;
    int cyc, pulses, bad;
    logic [7:0] v;
    pulses = 0; bad = 0;
    busy8 = 1'b1;
    send8(8'h0D, 8'h50, 8'h05);
    for (int i = 0; i < 20; i++) begin
      din8 = 8'h0A; en8 = 1'b1;
      @(negedge clk);
      if (endo8) pulses++;
      if (dout8 !== 8'h55) bad++;
    end
    en8 = 1'b0;
    nchk++; if (pulses !== 0) begin nerr++; $display("[TB] FAIL busy_no_strobe got %0d exp 0", pulses); end
    nchk++; if (bad !== 0) begin nerr++; $display("[TB] FAIL busy_dout_stable got %0d bad exp 0", bad); end
    busy8 = 1'b0;
    wait8(cyc, v);
    nchk++; if ({cyc, v} !== {32'd1, 8'h55}) begin
      nerr++; $display("[TB] FAIL busy_release got cyc=%0d dout=%h exp 1/55", cyc, v);
    end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
    nchk++; if ({endo8, dout8} !== {1'b1, 8'h00}) begin
      nerr++; $display("[TB] FAIL busy_status got en=%b dout=%h exp 1/00", endo8, dout8);
    end
`endif
    send8(8'h0A, 8'h01, 8'h02);
    wait8(cyc, v);
    nchk++; if ({cyc, v} !== {32'd2, 8'h03}) begin
      nerr++; $display("[TB] FAIL busy_next_frame got cyc=%0d dout=%h exp 2/03", cyc, v);
    end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    int cyc, quiet;
    logic [31:0] v;
    send32(32'h0D, 32'h12345678, 32'h0);
    wait32(cyc, v);
    nchk++; if (v !== 32'h12345678) begin nerr++; $display("[TB] FAIL w32_or got %h exp 12345678", v); end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
`endif
    @(negedge clk);
    din32 = 32'h0A; en32 = 1'b1; @(negedge clk);
    din32 = 32'hFFFFFFFF; @(negedge clk);
    en32 = 1'b0;
    nchk++; if (idle32 !== 1'b0) begin nerr++; $display("[TB] FAIL w32_in_frame got idle=%b exp 0", idle32); end
    #2 res32 = 1'b0;
    #1;
    nchk++; if ({dout32, endo32, err32, idle32} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      nerr++; $display("[TB] FAIL w32_async_reset got dout=%h en=%b err=%b idle=%b", dout32, endo32, err32, idle32);
    end
    quiet = 0;
    repeat (3) begin
      @(negedge clk);
      if (endo32 || err32) quiet++;
    end
    nchk++; if (quiet !== 0) begin nerr++; $display("[TB] FAIL w32_reset_quiet got %0d exp 0", quiet); end
    res32 = 1'b1;
    @(negedge clk);
    send32(32'h0A, 32'hFFFFFFFF, 32'h1);
    wait32(cyc, v);
    nchk++; if ({cyc, v} !== {32'd2, 32'h0}) begin
      nerr++; $display("[TB] FAIL w32_add_wrap got cyc=%0d dout=%h exp 2/00000000", cyc, v);
    end
`ifdef CMD_PRO_STATUS_EN
    @(negedge clk);
    nchk++; if ({endo32, dout32} !== {1'b1, 32'h3}) begin
      nerr++; $display("[TB] FAIL w32_status got en=%b dout=%h exp 1/00000003", endo32, dout32);
    end
`endif
  endtask

  initial begin
    res8 = 1'b0; res32 = 1'b0;
    din8 = '0; en8 = 1'b0; busy8 = 1'b0;
    din32 = '0; en32 = 1'b0; busy32 = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_bad_opcode();
    test_timeout();
    test_busy();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cmd_pro_gen.md
# cmd_pro_gen

Parametrised byte/word-serial command processor for the UART-fed command path. It accepts a three-word frame (opcode, operand A, operand B) on a strobed input and computes one of six ALU operations at WIDTH bits. It returns the result through a busy-gated output strobe. It adds an inter-word timeout, error reporting for bad opcodes or stalled frames, and an optional status word.

## Interface
- WIDTH, 8, data width of operands and result. Legal values are 8, 16 and 32. The opcode is din_pro[7:0]; upper bits of the opcode word are ignored.
- TIMEOUT, 1000, idle clocks allowed between accepted words inside a frame. 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- din_pro  in  WIDTH  input word.
- en_din_pro  in  1  input strobe. Each clock it is high transfers one word.
- tx_busy  in  1  downstream busy. An output strobe is only issued while it is low.
- dout_pro  out  WIDTH  result or status word. Held stable until the next output.
- en_dout_pro  out  1  one-clock output strobe.
- err  out  1  one-clock pulse on a bad opcode or a timeout.
- idle  out  1  high in IDLE.

## Operation
- Reset values: all state registers reset to IDLE. dout_pro=0, en_dout_pro=0, err=0, idle=1, timeout counter=0.
- Opcodes:
  - 0x0A: A+B.
  - 0x0B: A-B (modulo 2^WIDTH).
  - 0x0C: A&B.
  - 0x0D: A|B.
  - 0x0E: A^B.
  - 0x0F: A << (B mod WIDTH), zero fill.
- Flags, computed in CALC:
  - carry: bit WIDTH of A+B for 0x0A; borrow (A<B unsigned) for 0x0B; 0 for all other opcodes.
  - zero: result==0.
- FSM states: IDLE, GET_A, GET_B, CALC, SEND, SEND_ST (SEND_ST exists only with the macro).
- IDLE:
  - On en_din_pro with a legal opcode: latch the opcode, go to GET_A.
  - On en_din_pro with an illegal opcode: err=1 for one clock, stay in IDLE, nothing latched.
- GET_A / GET_B:
  - On en_din_pro: latch the word, clear the counter, advance.
  - Otherwise increment the counter. When it reaches TIMEOUT: err=1 for one clock, go to IDLE, discard the partial frame.
- CALC: register the result and flags into dout_pro/flag registers, go to SEND. Single clock, unconditional.
- SEND:
  - While tx_busy=1, wait indefinitely. No timeout applies.
  - When tx_busy=0: en_dout_pro=1 for one clock, then go to SEND_ST (with macro) or IDLE.
- en_din_pro during CALC, SEND or SEND_ST is ignored and the word is lost. The transmitter must not send the next frame before the output is seen.
- Reset asserted mid-frame returns everything to reset values immediately. No output or err is produced.

## Timing
- Latency: with tx_busy low, en_dout_pro is high in the clock that begins 3 edges after the edge that samples B. The B edge leads to CALC, CALC leads to SEND, and SEND issues the strobe.
- en_dout_pro and err are registered, one clock wide, and never high in consecutive cycles from the same event.
- Back-to-back frames: the opcode of the next frame can be accepted on the clock after the last en_dout_pro.
- Timeout boundary:
  - A word arriving on the same edge that the counter would reach TIMEOUT is accepted, and no error is raised.
  - TIMEOUT=1 means the next word must arrive on the very next clock.
- Simultaneous tx_busy deassert and SEND entry: the strobe is issued on the first SEND clock in which tx_busy is low.

## Configuration
- CMD_PRO_STATUS_EN defined: after the result strobe, SEND_ST waits for tx_busy=0 under the same rules as SEND. It then drives dout_pro={zeros, carry, zero} (bit1=carry, bit0=zero) with one further en_dout_pro, then goes to IDLE. Each frame yields two output words.
- CMD_PRO_STATUS_EN undefined: SEND goes directly to IDLE. Flags are not observable, and one output word is produced per frame.

## Test plan
- WIDTH=8, frame 0x0A,0xF0,0x20, tx_busy=0 -> dout_pro=0x10, one en_dout_pro, 3 clocks after B. With macro, second word 0x02.
- WIDTH=8, frame 0x0B,0x05,0x05 then 0x0F,0x81,0x09 -> outputs 0x00 (status 0x01 with macro), then 0x02.
- Opcode 0x33 -> err pulses exactly once, idle stays 1, no en_dout_pro. A following frame 0x0E,0xAA,0xFF gives 0x55.
- TIMEOUT=4, send 0x0C then A, then wait 4 clocks -> err pulse, idle=1. With the next word on clock 4 instead, the frame completes normally.
- tx_busy held 1 for 20 clocks after B -> no strobe and dout_pro stable. The strobe follows in the first clock after tx_busy falls. Extra en_din_pro during the wait is ignored.
- WIDTH=32, 0x0A,0xFFFFFFFF,0x1; assert res low while in GET_B -> outputs return to reset values at once. After release, this frame produces 0x00000000 (status 0x3 with macro).
